btn_debounce_n: RTL and testbench

Parametrised multi-channel push-button front end for the board top level: synchronises N raw button/switch inputs, debounces them against a shared millisecond tick, and produces clean levels, single-cycle press/release pulses and optional auto-repeat press pulses. It replaces the fixed two-button scanner feeding the CPU debug-step and interrupt controls. It also serves the extra board buttons used by the debug/UART path.

---
 rtl/btn_debounce_n_pkg.sv | 14 +
 rtl/btn_debounce_n_chan.sv | 91 +++++++++
 rtl/btn_debounce_n.sv | 56 +++++
 tb/tb_btn_debounce_n.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/btn_debounce_n_pkg.sv
// Shared defaults and width helper for the multi-channel button debouncer.
package btn_debounce_n_pkg;

  localparam int DEF_CLK_FREQ        = 25;
  localparam int DEF_DEBOUNCE_MS     = 10;
  localparam int DEF_REPEAT_DELAY_MS = 500;
  localparam int DEF_REPEAT_RATE_MS  = 100;

  // Counter width for values 0..val-1, never narrower than one bit.
  function automatic int width_of(input int val);
    return (val > 1) ? $clog2(val) : 1;
  endfunction

endpackage

// File: rtl/btn_debounce_n_chan.sv
// One button channel: polarity fix, two-flop synchroniser, tick-based debounce,
// auto-repeat counter and registered level/press/release outputs.
module btn_chan
  import btn_debounce_n_pkg::*;
#(
  parameter int DEBOUNCE_MS     = DEF_DEBOUNCE_MS,
  parameter int REPEAT_DELAY_MS = DEF_REPEAT_DELAY_MS,
  parameter int REPEAT_RATE_MS  = DEF_REPEAT_RATE_MS
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic btn_raw,
  input  logic inv,
  input  logic repeat_en,
  output logic level,
  output logic press,
  output logic release_pulse
);

  localparam int CW = width_of(DEBOUNCE_MS + 1);
  localparam int RW = width_of(REPEAT_DELAY_MS + 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          rel_q, rel_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] rep_q, rep_d;

  always_comb begin
    sync1_d = btn_raw ^ inv;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    rep_d   = rep_q;
    press_d = 1'b0;
    rel_d   = 1'b0;

    if (tick) begin
      if (sync2_q == level_q) begin
        cnt_d = '0;
      end else if (cnt_q == CW'(DEBOUNCE_MS - 1)) begin
        cnt_d   = '0;
        level_d = ~level_q;
        press_d = ~level_q;
        rel_d   = level_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end

    // Repeat only fires while the button stays pressed through this edge.
    if (!level_q || !repeat_en) begin
      rep_d = '0;
    end else if (tick) begin
      if (rep_q == RW'(REPEAT_DELAY_MS - 1)) begin
        rep_d = RW'(REPEAT_DELAY_MS - REPEAT_RATE_MS);
        if (level_d) press_d = 1'b1;
      end else begin
        rep_d = rep_q + RW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      cnt_q   <= '0;
      rep_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      cnt_q   <= cnt_d;
      rep_q   <= rep_d;
    end
  end

  assign level         = level_q;
  assign press         = press_q;
  assign release_pulse = rel_q;

endmodule

// File: rtl/btn_debounce_n.sv
// Multi-channel push-button front end: shared millisecond prescaler feeding
// one debounce/repeat channel per button.
module btn_debounce_n
  import btn_debounce_n_pkg::*;
#(
  parameter int               N_BTN           = 5,
  parameter int               CLK_FREQ        = DEF_CLK_FREQ,
  parameter int               TICK_CYCLES     = CLK_FREQ * 1000,
  parameter int               DEBOUNCE_MS     = DEF_DEBOUNCE_MS,
  parameter int               REPEAT_DELAY_MS = DEF_REPEAT_DELAY_MS,
  parameter int               REPEAT_RATE_MS  = DEF_REPEAT_RATE_MS,
  parameter logic [N_BTN-1:0] INV_MASK        = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_in,
  input  logic [N_BTN-1:0] repeat_en,
  output logic [N_BTN-1:0] level,
  output logic [N_BTN-1:0] press,
  output logic [N_BTN-1:0] release_pulse
);

  localparam int PW = width_of(TICK_CYCLES);

  logic [PW-1:0] presc_q, presc_d;
  logic          tick;

  always_comb begin
    tick    = (presc_q == PW'(TICK_CYCLES - 1));
    presc_d = tick ? '0 : presc_q + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) presc_q <= '0;
    else     presc_q <= presc_d;
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    btn_chan #(
      .DEBOUNCE_MS    (DEBOUNCE_MS),
      .REPEAT_DELAY_MS(REPEAT_DELAY_MS),
      .REPEAT_RATE_MS (REPEAT_RATE_MS)
    ) u_chan (
      .clk          (clk),
      .rst          (rst),
      .tick         (tick),
      .btn_raw      (btn_in[i]),
      .inv          (INV_MASK[i]),
      .repeat_en    (repeat_en[i]),
      .level        (level[i]),
      .press        (press[i]),
      .release_pulse(release_pulse[i])
    );
  end

endmodule

// File: tb/tb_btn_debounce_n.sv
// Scoreboard bench for btn_debounce_n: stimulus queues expected pulses, a
// negedge monitor pops and checks them whenever a press/release pulse appears.
module tb_btn_debounce_n;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] btn_in;
  logic [2:0] repeat_en;
  logic [2:0] level;
  logic [2:0] press;
  logic [2:0] release_pulse;

  btn_debounce_n #(
    .N_BTN          (3),
    .TICK_CYCLES    (4),
    .DEBOUNCE_MS    (3),
    .REPEAT_DELAY_MS(5),
    .REPEAT_RATE_MS (2),
    .INV_MASK       (3'b100)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_in       (btn_in),
    .repeat_en    (repeat_en),
    .level        (level),
    .press        (press),
    .release_pulse(release_pulse)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string      name;
    logic [2:0] press;
    logic [2:0] rel;
    logic [2:0] level;
    int         lo;
    int         hi;
    bit         relative;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   last_pulse_cyc = 0;
  int   drive_cyc = 0;

  task automatic checkOutput(input string name, input logic [2:0] act, input logic [2:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %b, expected %b (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic checkWindow(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("[TB] FAIL %s_time: cycle %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Drive inputs at a negedge and remember when, for latency windows.
  task automatic applyStimulus(input logic [2:0] b, input logic [2:0] en);
    @(negedge clk);
    btn_in    = b;
    repeat_en = en;
    drive_cyc = cyc;
  endtask

  task automatic expectPulse(input string name, input logic [2:0] p, input logic [2:0] r,
                             input logic [2:0] l, input int lo, input int hi, input bit relative);
    exp_t e;
    e.name = name; e.press = p; e.rel = r; e.level = l;
    e.lo = lo; e.hi = hi; e.relative = relative;
    exp_q.push_back(e);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if ((press | release_pulse) != 3'b000) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_pulse: press=%b release=%b at cycle %0d, expected none",
                 press, release_pulse, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput({mon_e.name, "_press"}, press, mon_e.press);
        checkOutput({mon_e.name, "_release"}, release_pulse, mon_e.rel);
        checkOutput({mon_e.name, "_level"}, level, mon_e.level);
        if (mon_e.relative)
          checkWindow(mon_e.name, cyc, last_pulse_cyc + mon_e.lo, last_pulse_cyc + mon_e.hi);
        else
          checkWindow(mon_e.name, cyc, mon_e.lo, mon_e.hi);
        last_pulse_cyc = cyc;
      end
    end
  end

  initial begin
    rst       = 1'b1;
    btn_in    = 3'b100;
    repeat_en = 3'b000;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("reset_level", level, 3'b000);
      checkOutput("reset_pulses", press | release_pulse, 3'b000);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("idle_level", level, 3'b000);
    end

    // Clean press and release on channel 0.
    applyStimulus(3'b101, 3'b000);
    expectPulse("ch0_press", 3'b001, 3'b000, 3'b001, drive_cyc + 11, drive_cyc + 18, 1'b0);
    waitCycles(30);
    applyStimulus(3'b100, 3'b000);
    expectPulse("ch0_release", 3'b000, 3'b001, 3'b000, drive_cyc + 11, drive_cyc + 18, 1'b0);
    waitCycles(30);

    // Glitch on channel 1 lasting two ticks.
    applyStimulus(3'b110, 3'b000);
    waitCycles(7);
    applyStimulus(3'b100, 3'b000);
    waitCycles(30);
    checkOutput("glitch_level", level, 3'b000);

    // Auto-repeat on channel 0, then drop repeat_en before the fourth repeat.
    applyStimulus(3'b101, 3'b001);
    expectPulse("rep_edge", 3'b001, 3'b000, 3'b001, drive_cyc + 11, drive_cyc + 18, 1'b0);
    expectPulse("rep_1", 3'b001, 3'b000, 3'b001, 20, 20, 1'b1);
    expectPulse("rep_2", 3'b001, 3'b000, 3'b001, 8, 8, 1'b1);
    expectPulse("rep_3", 3'b001, 3'b000, 3'b001, 8, 8, 1'b1);
    waitCycles(51);
    applyStimulus(3'b101, 3'b000);
    waitCycles(40);
    checkOutput("rep_off_level", level, 3'b001);
    applyStimulus(3'b100, 3'b000);
    expectPulse("rep_release", 3'b000, 3'b001, 3'b000, drive_cyc + 11, drive_cyc + 18, 1'b0);
    waitCycles(30);

    // Active-low channel 2, with reset asserted while held.
    applyStimulus(3'b000, 3'b000);
    expectPulse("ch2_press", 3'b100, 3'b000, 3'b100, drive_cyc + 11, drive_cyc + 18, 1'b0);
    waitCycles(30);
    checkOutput("ch2_level", level, 3'b100);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("ch2_rst_level", level, 3'b000);
    checkOutput("ch2_rst_pulses", press | release_pulse, 3'b000);
    @(negedge clk);
    rst = 1'b0;
    drive_cyc = cyc;
    expectPulse("ch2_repress", 3'b100, 3'b000, 3'b100, drive_cyc + 11, drive_cyc + 18, 1'b0);
    waitCycles(30);
    applyStimulus(3'b100, 3'b000);
    expectPulse("ch2_release", 3'b000, 3'b100, 3'b000, drive_cyc + 11, drive_cyc + 18, 1'b0);
    waitCycles(30);

    // Simultaneous press and release on channels 0 and 1.
    applyStimulus(3'b111, 3'b000);
    expectPulse("dual_press", 3'b011, 3'b000, 3'b011, drive_cyc + 11, drive_cyc + 18, 1'b0);
    waitCycles(30);
    applyStimulus(3'b100, 3'b000);
    expectPulse("dual_release", 3'b000, 3'b011, 3'b000, drive_cyc + 11, drive_cyc + 18, 1'b0);

    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    waitCycles(10);
    while (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      checks++;
      errors++;
      $display("[TB] FAIL %s_missing: no pulse seen, expected press=%b release=%b",
               mon_e.name, mon_e.press, mon_e.rel);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
